// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, controller state encoding and the
// bit-reversal helper used for natural-to-bitrev sample placement.
package fft_pkg;

    localparam int LOG2N     = 6;
    localparam int BF_LAT    = 3;
    localparam int DRAIN_CYC = 4;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN,
        UNLOAD
    } state_t;

    // Reverses the low w bits of x (w <= 10).
    function automatic logic [9:0] bitrev(
        input logic [9:0] x,
        input int         w
    );
        logic [9:0] r;
        for (int i = 0; i < 10; i++)
            r[i] = x[9-i];
        return r >> (10 - w);
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: registered N/2-entry Q1.15 twiddle table,
// W(k) = cos(2*pi*k/N) - j*sin(2*pi*k/N), built at elaboration.
module fft_twiddle_rom #(
    parameter int DW = 16,
    parameter int N  = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] wr,
    output logic [DW-1:0] wi
);
    import fft_pkg::*;

    localparam real PI = 3.14159265358979323846;
    localparam real FS = real'((2 ** (DW - 1)) - 1);

    logic [DW-1:0] rom_wr [N/2];
    logic [DW-1:0] rom_wi [N/2];

    for (genvar g = 0; g < N / 2; g++) begin : g_tw
        localparam real C  = FS * $cos(2.0 * PI * g / N);
        localparam real S  = -FS * $sin(2.0 * PI * g / N);
        localparam int  CI = (C >= 0.0) ? $rtoi(C + 0.5)
                                        : -$rtoi(0.5 - C);
        localparam int  SI = (S >= 0.0) ? $rtoi(S + 0.5)
                                        : -$rtoi(0.5 - S);
        assign rom_wr[g] = DW'(CI);
        assign rom_wi[g] = DW'(SI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr <= '0;
            wi <= '0;
        end else if (en) begin
            wr <= rom_wr[addr];
            wi <= rom_wi[addr];
        end
    end

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: in-place radix-2 DIT FFT sequencer driving one external
// butterfly; owns sample memory, addressing, twiddles and writeback.
module fft_ctrl #(
    parameter int DW    = 16,
    parameter int N     = 64,
    parameter int LOG2N = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          bf_valid,
    output logic [DW-1:0] bf_ar,
    output logic [DW-1:0] bf_ai,
    output logic [DW-1:0] bf_br,
    output logic [DW-1:0] bf_bi,
    output logic [DW-1:0] bf_wr,
    output logic [DW-1:0] bf_wi,
    input  logic          bf_valid_out,
    input  logic [DW-1:0] bf_pr,
    input  logic [DW-1:0] bf_pi,
    input  logic [DW-1:0] bf_qr,
    input  logic [DW-1:0] bf_qi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          busy
);
    import fft_pkg::*;

    localparam int HW = LOG2N - 1;
    typedef logic [LOG2N-1:0] addr_t;

    state_t        state;
    logic [DW-1:0] mem_re [N];
    logic [DW-1:0] mem_im [N];
    addr_t         cnt;
    logic [HW-1:0] bcnt;
    logic [3:0]    stg;
    logic [2:0]    dcnt;
    addr_t         bx, hmask, j, top, bot;
    logic [HW-1:0] tw_k;
    addr_t         ad_top [BF_LAT+1];
    addr_t         ad_bot [BF_LAT+1];
    addr_t         ld_addr;
    logic          ld_en, wb_en, issue;

    // Butterfly b of stage s pairs top and top+2^s.
    always_comb begin
        bx    = addr_t'(bcnt);
        hmask = (addr_t'(1) << stg) - addr_t'(1);
        j     = bx & hmask;
        top   = ((bx >> stg) << (stg + 4'd1)) | j;
        bot   = top | (addr_t'(1) << stg);
        tw_k  = HW'(j << (HW - int'(stg)));
    end

    assign issue   = (state == COMPUTE);
    assign ld_en   = (state == LOAD) && in_ready && in_valid;
    assign ld_addr = addr_t'(bitrev(10'(cnt), LOG2N));
    assign wb_en   = bf_valid_out &&
                     (state == COMPUTE || state == DRAIN);

    fft_twiddle_rom #(
        .DW (DW),
        .N  (N),
        .AW (HW)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue),
        .addr  (tw_k),
        .wr    (bf_wr),
        .wi    (bf_wi)
    );

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_re[ld_addr] <= in_re;
            mem_im[ld_addr] <= in_im;
        end else if (wb_en) begin
            mem_re[ad_top[BF_LAT]] <= bf_pr;
            mem_im[ad_top[BF_LAT]] <= bf_pi;
            mem_re[ad_bot[BF_LAT]] <= bf_qr;
            mem_im[ad_bot[BF_LAT]] <= bf_qi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= '0;
            bcnt      <= '0;
            stg       <= '0;
            dcnt      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            bf_valid  <= 1'b0;
            bf_ar     <= '0;
            bf_ai     <= '0;
            bf_br     <= '0;
            bf_bi     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            for (int i = 0; i <= BF_LAT; i++) begin
                ad_top[i] <= '0;
                ad_bot[i] <= '0;
            end
        end else begin
            bf_valid <= 1'b0;
            for (int i = 1; i <= BF_LAT; i++) begin
                ad_top[i] <= ad_top[i-1];
                ad_bot[i] <= ad_bot[i-1];
            end
            unique case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (ld_en) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            stg      <= '0;
                            bcnt     <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    bf_valid  <= 1'b1;
                    bf_ar     <= mem_re[top];
                    bf_ai     <= mem_im[top];
                    bf_br     <= mem_re[bot];
                    bf_bi     <= mem_im[bot];
                    ad_top[0] <= top;
                    ad_bot[0] <= bot;
                    bcnt      <= bcnt + 1'b1;
                    if (&bcnt) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == 3'(DRAIN_CYC - 1)) begin
                        dcnt <= '0;
                        if (stg == 4'(LOG2N - 1)) begin
                            state <= UNLOAD;
                            cnt   <= '0;
                        end else begin
                            stg   <= stg + 1'b1;
                            state <= COMPUTE;
                        end
                    end
                end
                UNLOAD: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                        cnt       <= '0;
                        stg       <= '0;
                    end else if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        out_re    <= mem_re[cnt];
                        out_im    <= mem_im[cnt];
                        out_last  <= &cnt;
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: drives frames into fft_ctrl with a 3-cycle butterfly
// model and scores the bins against a floating-point DFT.
module tb_fft_ctrl;

    localparam int    DW = 16;
    localparam int    N  = 64;
    localparam real   PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          bf_valid;
    logic [DW-1:0] bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi;
    logic          bf_valid_out;
    logic [DW-1:0] bf_pr, bf_pi, bf_qr, bf_qi;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_re, out_im;
    logic          out_last;
    logic          busy;

    typedef struct {
        int re;
        int im;
        bit last;
        int tol;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   x_re [N];
    int   x_im [N];
    bit   rand_ready = 1'b0;
    int   bf_cnt = 0;

    always #5 clk = ~clk;

    fft_ctrl #(.DW(DW), .N(N), .LOG2N(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_re        (in_re),
        .in_im        (in_im),
        .bf_valid     (bf_valid),
        .bf_ar        (bf_ar),
        .bf_ai        (bf_ai),
        .bf_br        (bf_br),
        .bf_bi        (bf_bi),
        .bf_wr        (bf_wr),
        .bf_wi        (bf_wi),
        .bf_valid_out (bf_valid_out),
        .bf_pr        (bf_pr),
        .bf_pi        (bf_pi),
        .bf_qr        (bf_qr),
        .bf_qi        (bf_qi),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_re       (out_re),
        .out_im       (out_im),
        .out_last     (out_last),
        .busy         (busy)
    );

    // Butterfly model: P = A + W*B, Q = A - W*B, wrapping, 3-cycle latency
    longint t_r, t_i, a_r, a_i;
    always_comb begin
        a_r = longint'($signed(bf_ar));
        a_i = longint'($signed(bf_ai));
        t_r = (longint'($signed(bf_br)) * $signed(bf_wr)
             - longint'($signed(bf_bi)) * $signed(bf_wi) + 16384) >>> 15;
        t_i = (longint'($signed(bf_br)) * $signed(bf_wi)
             + longint'($signed(bf_bi)) * $signed(bf_wr) + 16384) >>> 15;
    end

    logic          bv  [3];
    logic [DW-1:0] bpr [3];
    logic [DW-1:0] bpi [3];
    logic [DW-1:0] bqr [3];
    logic [DW-1:0] bqi [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) bv[i] <= 1'b0;
        end else begin
            bv[0]  <= bf_valid;
            bpr[0] <= 16'(a_r + t_r);
            bpi[0] <= 16'(a_i + t_i);
            bqr[0] <= 16'(a_r - t_r);
            bqi[0] <= 16'(a_i - t_i);
            for (int i = 1; i < 3; i++) begin
                bv[i]  <= bv[i-1];
                bpr[i] <= bpr[i-1];
                bpi[i] <= bpi[i-1];
                bqr[i] <= bqr[i-1];
                bqi[i] <= bqi[i-1];
            end
        end
    end

    assign bf_valid_out = bv[2];
    assign bf_pr = bpr[2];
    assign bf_pi = bpi[2];
    assign bf_qr = bqr[2];
    assign bf_qi = bqi[2];

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) if (bf_valid) bf_cnt++;

    // Scoreboard: each accepted bin is compared with the head of exp_q
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bin: got (%0d,%0d), required no output",
                         $signed(out_re), $signed(out_im));
            end else begin
                exp_t e;
                int   k, d;
                k = N - exp_q.size();
                e = exp_q.pop_front();
                d = int'($signed(out_re)) - e.re;
                checks++;
                if ((d < 0 ? -d : d) > e.tol) begin
                    errors++;
                    $display("FAIL bin_re[%0d]: got %0d, required %0d +-%0d",
                             k, $signed(out_re), e.re, e.tol);
                end
                d = int'($signed(out_im)) - e.im;
                checks++;
                if ((d < 0 ? -d : d) > e.tol) begin
                    errors++;
                    $display("FAIL bin_im[%0d]: got %0d, required %0d +-%0d",
                             k, $signed(out_im), e.im, e.tol);
                end
                checks++;
                if (out_last !== e.last) begin
                    errors++;
                    $display("FAIL out_last[%0d]: got %0b, required %0b",
                             k, out_last, e.last);
                end
            end
        end
    end

    // Outputs must hold while a valid bin is stalled
    logic          st_p = 1'b0;
    logic [DW-1:0] st_re, st_im;
    logic          st_last;
    always @(negedge clk) begin
        if (rst_n && st_p) begin
            checks++;
            if (out_valid !== 1'b1 || out_re !== st_re ||
                out_im !== st_im || out_last !== st_last) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b (%0d,%0d,%0b), required v=1 (%0d,%0d,%0b)",
                         out_valid, $signed(out_re), $signed(out_im), out_last,
                         $signed(st_re), $signed(st_im), st_last);
            end
        end
        st_p    = rst_n && out_valid && !out_ready;
        st_re   = out_re;
        st_im   = out_im;
        st_last = out_last;
    end

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic push_expected(input int tol);
        for (int k = 0; k < N; k++) begin
            real  sr, si, ang;
            exp_t e;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = 2.0 * PI * n * k / N;
                sr += x_re[n] * $cos(ang) + x_im[n] * $sin(ang);
                si += x_im[n] * $cos(ang) - x_re[n] * $sin(ang);
            end
            e.re   = rnd(sr);
            e.im   = rnd(si);
            e.last = (k == N - 1);
            e.tol  = tol;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_frame(input int kind);
        for (int n = 0; n < N; n++) begin
            x_im[n] = 0;
            case (kind)
                0: x_re[n] = (n == 0) ? 1000 : 0;
                1: x_re[n] = 100;
                2: x_re[n] = rnd(200.0 * $cos(2.0 * PI * n * 4 / N));
                default: x_re[n] = (n == 1) ? 1000 : 0;
            endcase
        end
    endtask

    task automatic load_frame(output bit ok);
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) ok = 1'b0;
            in_valid = 1'b1;
            in_re    = 16'(x_re[i]);
            in_im    = 16'(x_im[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        ok = (exp_q.size() == 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%0b busy=%0b ov=%0b, required 0 0 0",
                     in_ready, busy, out_valid);
        end
        checks++;
        if (bf_valid !== 1'b0 || bf_wr !== '0 || out_re !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got bfv=%0b wr=%0h ore=%0h last=%0b, required 0",
                     bf_valid, bf_wr, out_re, out_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%0b busy=%0b, required 1 0",
                     in_ready, busy);
        end
    endtask

    task automatic run_frame(input string name, input int kind, input int tol);
        bit ok;
        set_frame(kind);
        push_expected(tol);
        bf_cnt = 0;
        load_frame(ok);
        checks++;
        if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_rise: got ok=%0b busy=%0b rdy=%0b, required 1 1 0",
                     name, ok, busy, in_ready);
        end
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got bins missing, required all %0d", name, N);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_fall: got busy=%0b rdy=%0b, required 0 1",
                     name, busy, in_ready);
        end
        checks++;
        if (bf_cnt !== 6 * N / 2) begin
            errors++;
            $display("FAIL %s_bf_issues: got %0d, required %0d", name, bf_cnt, 6 * N / 2);
        end
    endtask

    task automatic test_impulse();
        run_frame("impulse", 0, 1);
    endtask

    task automatic test_dc();
        run_frame("dc", 1, 4);
    endtask

    task automatic test_tone();
        run_frame("tone", 2, 8);
    endtask

    task automatic test_backpressure();
        rand_ready = 1'b1;
        run_frame("backpressure", 0, 1);
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid_compute();
        bit ok;
        set_frame(1);
        load_frame(ok);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || bf_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold: got busy=%0b rdy=%0b bfv=%0b, required 0 0 0",
                     busy, in_ready, bf_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_release: got busy=%0b rdy=%0b, required 0 1",
                     busy, in_ready);
        end
        run_frame("dc_after_rst", 1, 4);
    endtask

    task automatic test_in_valid_ignored();
        bit ok;
        int guard;
        set_frame(3);
        push_expected(4);
        load_frame(ok);
        guard = 0;
        in_valid = 1'b1;
        while (exp_q.size() != 0 && guard < 5000) begin
            in_re = 16'($urandom);
            in_im = 16'($urandom);
            @(negedge clk);
            guard++;
            if (busy) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_rdy: got %0b, required 0 while busy", in_ready);
                end
            end
        end
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignore_timeout: got bins missing, required all %0d", N);
        end
        run_frame("after_ignore", 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_tone();
        test_backpressure();
        test_reset_mid_compute();
        test_in_valid_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
